instr_encoder: RTL and testbench

Encoder-side counterpart of the opcode decoder. It accepts symbolic instruction requests (kind plus register and immediate fields) over a valid/ready handshake and packs them into 32-bit MIPS words. The words are buffered in a small FIFO and written sequentially into instruction memory, starting at a programmable base word address. It is used as the program loader and bench stimulus source for the pipelined core.

---
 rtl/instr_encoder_pkg.sv | 72 +++++++
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_encoder_enc_fifo.sv | 85 ++++++++
 rtl/instr_encoder.sv | 144 ++++++++++++++
 tb/tb_instr_encoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the instruction encoder:
//   - instr_kind_e : 4-bit symbolic instruction kind carried on in_kind
//   - OP_*         : MIPS primary opcode constants
//   - NOP_WORD     : the all-zero word (sll $0,$0,0)
//   - kind_is_legal / kind_has_delay_slot / encode_instr helpers
// ---------------------------------------------------------------------------
package instr_enc_pkg;

  typedef enum logic [3:0] {
    KIND_RTYPE = 4'd0,
    KIND_ADDI  = 4'd1,
    KIND_ORI   = 4'd2,
    KIND_SLTI  = 4'd3,
    KIND_LW    = 4'd4,
    KIND_SW    = 4'd5,
    KIND_J     = 4'd6,
    KIND_BEQ   = 4'd7,
    KIND_BNE   = 4'd8
  } instr_kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Kinds 9..15 have no encoding; they are swallowed and flagged upstream.
  function automatic logic kind_is_legal(input logic [3:0] kind);
    return (kind <= 4'd8);
  endfunction

  // Control-transfer kinds that get a padding NOP when delay slots are filled.
  function automatic logic kind_has_delay_slot(input logic [3:0] kind);
    return (kind == KIND_J) || (kind == KIND_BEQ) || (kind == KIND_BNE);
  endfunction

  // Packs one request into a 32-bit MIPS word. Fields a kind does not use
  // are simply ignored; illegal kinds produce NOP_WORD (never pushed anyway).
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [25:0] imm
  );
    logic [31:0] w;
    w = NOP_WORD;
    case (instr_kind_e'(kind))
      KIND_RTYPE: w = {OP_SPECIAL, rs, rt, rd, 5'b00000, funct};
      KIND_ADDI:  w = {OP_ADDI, rs, rt, imm[15:0]};
      KIND_ORI:   w = {OP_ORI,  rs, rt, imm[15:0]};
      KIND_SLTI:  w = {OP_SLTI, rs, rt, imm[15:0]};
      KIND_LW:    w = {OP_LW,   rs, rt, imm[15:0]};
      KIND_SW:    w = {OP_SW,   rs, rt, imm[15:0]};
      KIND_J:     w = {OP_J,    imm[25:0]};
      KIND_BEQ:   w = {OP_BEQ,  rs, rt, imm[15:0]};
      KIND_BNE:   w = {OP_BNE,  rs, rt, imm[15:0]};
      default:    w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Request and instruction-memory write signals of the instruction encoder.
//   Request side : in_valid, in_ready, in_kind, in_rs, in_rt, in_rd,
//                  in_funct, in_imm
//   Memory side  : im_we, im_ready, im_addr, im_wdata
// Modports:
//   slave  - the encoder (consumes requests, drives memory writes)
//   master - the request source / memory model (bench or loader)
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [5:0]    in_funct;
  logic [25:0]   in_imm;

  logic          im_we;
  logic          im_ready;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
    output in_ready,
    output im_we, im_addr, im_wdata,
    input  im_ready
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
    input  in_ready,
    input  im_we, im_addr, im_wdata,
    output im_ready
  );
endinterface

// File: rtl/instr_encoder_enc_fifo.sv
// ---------------------------------------------------------------------------
// enc_fifo
// DEPTH x W synchronous FIFO that can take one or two words per push.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   clear        synchronous flush (wins over push and pop)
//   push, push2  push din0; with push2 also push din1 right behind it
//   din0, din1   data words
//   pop          drop the head word (ignored when empty)
//   dout         head word (undefined contents when empty)
//   empty, full  occupancy flags
//   free         number of free entries
// The caller must not push more words than 'free' allows.
// ---------------------------------------------------------------------------
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          push2,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] free
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] push_n;
  logic          pop_ok;

  // Number of words entering this cycle (0, 1 or 2).
  always_comb begin
    push_n = '0;
    if (push) begin
      push_n = push2 ? CW'(2) : CW'(1);
    end
  end

  assign pop_ok = pop & ~empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally because
  // DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_n[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop_ok);
      count  <= count + push_n - CW'(pop_ok);
    end
  end

  // Storage is not reset; 'empty' masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= din0;
      if (push2) begin
        mem[wr_ptr + PW'(1)] <= din1;
      end
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign free  = CW'(DEPTH) - count;

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs symbolic instruction requests into 32-bit MIPS words, buffers them
// in a small FIFO and writes them to consecutive instruction-memory word
// addresses starting at base_addr.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clear       synchronous flush: empties FIFO, reloads address, zeroes words
//   base_addr   start word address (sampled on reset release and on clear)
//   bus         instr_encoder_if.slave: request handshake + memory write port
//   words       completed writes since reset/clear, saturating
//   err         sticky flag: an illegal kind was accepted
// Build option:
//   ENC_DELAY_SLOT_EN - every J/BEQ/BNE is followed by a NOP word; requests
//                       are then only accepted with two free FIFO slots.
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [AW-1:0]     base_addr,
  instr_encoder_if.slave    bus,
  output logic [AW:0]       words,
  output logic              err
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef ENC_DELAY_SLOT_EN
  localparam int NEED_FREE = 2;
`else
  localparam int NEED_FREE = 1;
`endif

  logic          in_ready_w;
  logic          accept;
  logic          legal;
  logic [31:0]   enc_word;
  logic          push;
  logic          push2;
  logic          pop;
  logic [31:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_free;
  logic [AW-1:0] addr_q;
  logic          addr_loaded;
  logic [AW-1:0] cur_addr;
  logic [AW:0]   words_q;
  logic          err_q;

  // Readiness is gated by reset and clear directly so it is low
  // asynchronously in reset and during a flush cycle. The uniform free-slot
  // threshold means no pass-through when full, even if a pop is happening.
  assign in_ready_w = rst_n & ~clear & (fifo_free >= CW'(NEED_FREE));
  assign accept     = bus.in_valid & in_ready_w;

  assign legal    = kind_is_legal(bus.in_kind);
  assign enc_word = encode_instr(bus.in_kind, bus.in_rs, bus.in_rt,
                                 bus.in_rd, bus.in_funct, bus.in_imm);

  assign push = accept & legal;
`ifdef ENC_DELAY_SLOT_EN
  assign push2 = kind_has_delay_slot(bus.in_kind);
`else
  assign push2 = 1'b0;
`endif

  // A write completes on im_we & im_ready; clear cancels it.
  assign pop = ~fifo_empty & bus.im_ready & ~clear;

  enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .push2 (push2),
    .din0  (enc_word),
    .din1  (NOP_WORD),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .free  (fifo_free)
  );

  // Until the first clock after reset the address register has not sampled
  // base_addr yet, so base_addr is shown directly. From then on the register
  // owns the address (a write cannot complete in that first cycle because
  // the FIFO is still empty).
  assign cur_addr = addr_loaded ? addr_q : base_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      addr_loaded <= 1'b0;
    end else if (clear) begin
      addr_q      <= base_addr;
      addr_loaded <= 1'b1;
    end else begin
      addr_q      <= pop ? cur_addr + AW'(1) : cur_addr;
      addr_loaded <= 1'b1;
    end
  end

  // Completed-write counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (clear) begin
      words_q <= '0;
    end else if (pop && (words_q != {(AW+1){1'b1}})) begin
      words_q <= words_q + (AW+1)'(1);
    end
  end

  // Sticky illegal-kind flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.im_we    = ~fifo_empty;
  assign bus.im_addr  = cur_addr;
  assign bus.im_wdata = fifo_empty ? NOP_WORD : fifo_dout;
  assign words        = words_q;
  assign err          = err_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed, table-driven bench for instr_encoder (AW=8, DEPTH=4).
// Honours ENC_DELAY_SLOT_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

`ifdef ENC_DELAY_SLOT_EN
  localparam int EXP_ACCEPT = 3;
`else
  localparam int EXP_ACCEPT = 4;
`endif

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [AW-1:0] base_addr;
  logic [AW:0]   words;
  logic          err;

  vec_t vecs [11];
  int   vecCount  = 0;
  int   missCount = 0;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .base_addr (base_addr),
    .bus       (bus.slave),
    .words     (words),
    .err       (err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request on the interface with in_valid asserted.
  task automatic applyStimulus(input vec_t v);
    bus.in_kind  = v.kind;
    bus.in_rs    = v.rs;
    bus.in_rt    = v.rt;
    bus.in_rd    = v.rd;
    bus.in_funct = v.funct;
    bus.in_imm   = v.imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic applyAddi(input logic [15:0] imm);
    vec_t v;
    v = '{kind: 4'd1, rs: 5'd1, rt: 5'd2, rd: 5'd0, funct: 6'd0,
          imm: {10'd0, imm}, exp: 32'h0};
    applyStimulus(v);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] expAddr;
    int            expWords;

    vecs[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  6'h20, 26'h0,       32'h0022_1820};
    vecs[1]  = '{4'd1, 5'd1,  5'd2,  5'd0,  6'h00, 26'h0005,    32'h2022_0005};
    vecs[2]  = '{4'd4, 5'd29, 5'd8,  5'd0,  6'h00, 26'h0010,    32'h8FA8_0010};
    vecs[3]  = '{4'd2, 5'd3,  5'd4,  5'd9,  6'h3F, 26'h00FF,    32'h3464_00FF};
    vecs[4]  = '{4'd3, 5'd5,  5'd6,  5'd0,  6'h00, 26'h8000,    32'h28A6_8000};
    vecs[5]  = '{4'd5, 5'd29, 5'd31, 5'd0,  6'h00, 26'h0004,    32'hAFBF_0004};
    vecs[6]  = '{4'd6, 5'd0,  5'd0,  5'd0,  6'h00, 26'h100,     32'h0800_0100};
    vecs[7]  = '{4'd7, 5'd4,  5'd5,  5'd0,  6'h00, 26'hFFFF,    32'h1085_FFFF};
    vecs[8]  = '{4'd8, 5'd7,  5'd0,  5'd0,  6'h00, 26'h0010,    32'h14E0_0010};
    vecs[9]  = '{4'd0, 5'd0,  5'd0,  5'd31, 6'h2A, 26'h3FFFFFF, 32'h0000_F82A};
    vecs[10] = '{4'd6, 5'd31, 5'd31, 5'd0,  6'h00, 26'h3FFFFFF, 32'h0BFF_FFFF};

    rst_n        = 1'b0;
    clear        = 1'b0;
    base_addr    = 8'h10;
    bus.in_valid = 1'b0;
    bus.in_kind  = 4'd0;
    bus.in_rs    = 5'd0;
    bus.in_rt    = 5'd0;
    bus.in_rd    = 5'd0;
    bus.in_funct = 6'd0;
    bus.in_imm   = 26'd0;
    bus.im_ready = 1'b1;

    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_im_we",    32'(bus.im_we),    32'd0);
    checkOutput("rst_im_wdata", bus.im_wdata,      32'd0);
    checkOutput("rst_im_addr",  32'(bus.im_addr),  32'h10);
    checkOutput("rst_words",    32'(words),        32'd0);
    checkOutput("rst_err",      32'(err),          32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Streamed encoding table, one request per cycle, im_ready high
    expAddr  = 8'h10;
    expWords = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_im_we", i),    32'(bus.im_we),   32'd1);
      checkOutput($sformatf("vec%0d_im_wdata", i), bus.im_wdata,     vecs[i].exp);
      checkOutput($sformatf("vec%0d_im_addr", i),  32'(bus.im_addr), 32'(expAddr));
      expAddr++;
      expWords++;
`ifdef ENC_DELAY_SLOT_EN
      if (vecs[i].kind == 4'd6 || vecs[i].kind == 4'd7 || vecs[i].kind == 4'd8) begin
        idle();
        tick();
        checkOutput($sformatf("vec%0d_nop_wdata", i), bus.im_wdata,     32'd0);
        checkOutput($sformatf("vec%0d_nop_addr", i),  32'(bus.im_addr), 32'(expAddr));
        expAddr++;
        expWords++;
      end
`endif
    end
    idle();
    tick();
    checkOutput("stream_im_we_done", 32'(bus.im_we),   32'd0);
    checkOutput("stream_words",      32'(words),       32'(expWords));
    checkOutput("stream_addr_end",   32'(bus.im_addr), 32'(expAddr));
    checkOutput("stream_err",        32'(err),         32'd0);

    // Back-pressure: five requests against a stalled memory
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr1_im_addr", 32'(bus.im_addr), 32'h10);
    checkOutput("clr1_words",   32'(words),       32'd0);
    bus.im_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyAddi(16'(i));
      #1;
      checkOutput($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'(i < EXP_ACCEPT));
      tick();
    end
    idle();
    #1;
    checkOutput("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_hold_im_we",    32'(bus.im_we),    32'd1);
    checkOutput("bp_hold_wdata",    bus.im_wdata,      32'h2022_0000);
    tick();
    checkOutput("bp_hold_wdata2",   bus.im_wdata,      32'h2022_0000);
    checkOutput("bp_hold_addr",     32'(bus.im_addr),  32'h10);
    bus.im_ready = 1'b1;
    for (int j = 0; j < EXP_ACCEPT; j++) begin
      #1;
      checkOutput($sformatf("bp_drain%0d_wdata", j), bus.im_wdata,     32'h2022_0000 | 32'(j));
      checkOutput($sformatf("bp_drain%0d_addr", j),  32'(bus.im_addr), 32'h10 + 32'(j));
      tick();
    end
    checkOutput("bp_drain_im_we", 32'(bus.im_we), 32'd0);
    checkOutput("bp_drain_words", 32'(words),     32'(EXP_ACCEPT));

    // Illegal kind: swallowed, sticky error
    bus.in_kind  = 4'd12;
    bus.in_valid = 1'b1;
    tick();
    idle();
    checkOutput("ill_im_we", 32'(bus.im_we), 32'd0);
    checkOutput("ill_err",   32'(err),       32'd1);
    tick();
    checkOutput("ill_err_sticky", 32'(err),  32'd1);

    // Clear with three words buffered and a request pending
    bus.im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyAddi(16'h30 + 16'(i));
      tick();
    end
    idle();
    checkOutput("clr_pre_im_we", 32'(bus.im_we), 32'd1);
    base_addr = 8'h20;
    clear     = 1'b1;
    applyAddi(16'h55);
    #1;
    checkOutput("clr_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    idle();
    checkOutput("clr_im_we",   32'(bus.im_we),   32'd0);
    checkOutput("clr_im_addr", 32'(bus.im_addr), 32'h20);
    checkOutput("clr_words",   32'(words),       32'd0);
    checkOutput("clr_err",     32'(err),         32'd1);
    tick();
    checkOutput("clr_no_push", 32'(bus.im_we),   32'd0);

    // Address wrap from 0xFF
    base_addr = 8'hFF;
    clear     = 1'b1;
    tick();
    clear        = 1'b0;
    bus.im_ready = 1'b1;
    applyAddi(16'h0001);
    tick();
    checkOutput("wrap0_wdata", bus.im_wdata,     32'h2022_0001);
    checkOutput("wrap0_addr",  32'(bus.im_addr), 32'hFF);
    applyAddi(16'h0002);
    tick();
    checkOutput("wrap1_wdata", bus.im_wdata,     32'h2022_0002);
    checkOutput("wrap1_addr",  32'(bus.im_addr), 32'h00);
    idle();
    tick();
    checkOutput("wrap_words",  32'(words),       32'd2);
    checkOutput("wrap_addr_n", 32'(bus.im_addr), 32'h01);

    // Reset in the middle of a stalled stream
    bus.im_ready = 1'b0;
    applyAddi(16'h0011);
    tick();
    applyAddi(16'h0022);
    tick();
    idle();
    checkOutput("mid_pre_im_we", 32'(bus.im_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_im_we",    32'(bus.im_we),    32'd0);
    checkOutput("mid_rst_words",    32'(words),        32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("mid_rst_wdata",    bus.im_wdata,      32'd0);
    checkOutput("mid_rst_err",      32'(err),          32'd0);
    base_addr = 8'h10;
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_post_im_we", 32'(bus.im_we),   32'd0);
    checkOutput("mid_post_addr",  32'(bus.im_addr), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
